// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
// MD_MADD_EN adds the multiply-accumulate family to is_muldiv().
package md_pkg;

   typedef enum logic [3:0] {
      NONE  = 4'd0,
      MULT  = 4'd1,
      MULTU = 4'd2,
      DIV   = 4'd3,
      DIVU  = 4'd4,
      MFHI  = 4'd5,
      MFLO  = 4'd6,
      MTHI  = 4'd7,
      MTLO  = 4'd8,
      MADD  = 4'd9,
      MADDU = 4'd10,
      MSUB  = 4'd11,
      MSUBU = 4'd12
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // True for every op that occupies the unit for more than one cycle.
   function automatic logic is_muldiv(input md_op_e op);
      logic r;
      r = (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
`ifdef MD_MADD_EN
      r = r || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
      return r;
   endfunction

endpackage

// File: rtl/md_if.sv
// E-stage request / HI-LO result bundle between the pipeline and md_unit.
// Handshake: an op issues when start=1, Req=0 and busy=0; md_stall tells the hazard unit to hold E.
interface md_if;
   import md_pkg::*;

   logic        Req;
   logic        start;
   md_op_e      md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        md_stall;
   logic [31:0] HILO_res;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output Req, start, md_op, A, B,
                   input  busy, md_stall, HILO_res, HI, LO);
   modport slave  (input  Req, start, md_op, A, B,
                   output busy, md_stall, HILO_res, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO; result is computed at issue and committed after N busy cycles.
// Optional MADD/MADDU/MSUB/MSUBU enabled by MD_MADD_EN.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic      clk,
   input  logic      reset,
   md_if.slave       bus,
   output md_state_e dbg_state
);

   md_state_e   state, state_n;
   logic [3:0]  cnt;
   logic [31:0] hi_reg, lo_reg, hi_tmp, lo_tmp;
   logic        wr_pend;

   logic        issue, issue_md, commit;
   logic [63:0] prod_s, prod_u;
   logic [31:0] div_b;
   logic [31:0] q_s, r_s, q_u, r_u;
   logic [31:0] res_hi, res_lo;
   logic        res_wr;
   logic [3:0]  res_lat;
`ifdef MD_MADD_EN
   logic [63:0] acc;
`endif

   assign issue    = bus.start & ~bus.Req & (state == IDLE);
   assign issue_md = issue & is_muldiv(bus.md_op);
   assign commit   = (state == RUN) && (cnt == 4'd1);

   assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
   assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

   // Zero divisor and INT_MIN / -1 both divide by 1: the overflow case then yields
   // 0x80000000 rem 0 directly, and the zero case is discarded via res_wr.
   assign div_b = ((bus.B == 32'd0) || (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF))
                  ? 32'd1 : bus.B;
   assign q_s = $signed(bus.A) / $signed(div_b);
   assign r_s = $signed(bus.A) % $signed(div_b);
   assign q_u = bus.A / div_b;
   assign r_u = bus.A % div_b;

   always_comb begin
      res_hi  = 32'd0;
      res_lo  = 32'd0;
      res_wr  = 1'b1;
      res_lat = 4'(MULT_CYCLES);
`ifdef MD_MADD_EN
      acc     = {hi_reg, lo_reg};
`endif
      case (bus.md_op)
         MULT:  {res_hi, res_lo} = prod_s;
         MULTU: {res_hi, res_lo} = prod_u;
         DIV: begin
            res_hi  = r_s;
            res_lo  = q_s;
            res_wr  = (bus.B != 32'd0);
            res_lat = 4'(DIV_CYCLES);
         end
         DIVU: begin
            res_hi  = r_u;
            res_lo  = q_u;
            res_wr  = (bus.B != 32'd0);
            res_lat = 4'(DIV_CYCLES);
         end
`ifdef MD_MADD_EN
         MADD:  {res_hi, res_lo} = acc + prod_s;
         MADDU: {res_hi, res_lo} = acc + prod_u;
         MSUB:  {res_hi, res_lo} = acc - prod_s;
         MSUBU: {res_hi, res_lo} = acc - prod_u;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (issue_md) state_n = RUN;
         RUN:     if (commit)   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= 4'd0;
         hi_tmp  <= 32'd0;
         lo_tmp  <= 32'd0;
         wr_pend <= 1'b0;
         hi_reg  <= 32'd0;
         lo_reg  <= 32'd0;
      end else begin
         if (issue_md) begin
            cnt     <= res_lat;
            hi_tmp  <= res_hi;
            lo_tmp  <= res_lo;
            wr_pend <= res_wr;
         end else if (state == RUN) begin
            cnt <= cnt - 4'd1;
         end
         if (commit && wr_pend) begin
            hi_reg <= hi_tmp;
            lo_reg <= lo_tmp;
         end
         if (issue && bus.md_op == MTHI) hi_reg <= bus.A;
         if (issue && bus.md_op == MTLO) lo_reg <= bus.A;
      end
   end

   assign bus.busy     = (state == RUN);
   assign bus.md_stall = bus.busy | (bus.start & is_muldiv(bus.md_op) & ~bus.Req);
   assign bus.HILO_res = (bus.md_op == MFHI) ? hi_reg :
                         (bus.md_op == MFLO) ? lo_reg : 32'd0;
   assign bus.HI       = hi_reg;
   assign bus.LO       = lo_reg;
   assign dbg_state    = state;

endmodule

// File: tb/tb_md_unit.sv
// Directed-vector bench for md_unit: latency, results, Req suppression, divide-by-zero and async reset.
module tb_md_unit;
   import md_pkg::*;

   logic      clk;
   logic      reset;
   md_state_e dbg_state;
   md_if      bus ();

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // driver: present op at negedge, optionally check md_stall before the edge
   task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic req, input string tag, input logic exp_stall);
      @(negedge clk);
      bus.start = 1'b1;
      bus.Req   = req;
      bus.md_op = op;
      bus.A     = a;
      bus.B     = b;
      #1;
      check({tag, "_stall"}, 32'(bus.md_stall), 32'(exp_stall));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.Req   = 1'b0;
      bus.md_op = NONE;
   endtask

   // counts busy cycles after issue, bounded
   task automatic count_busy(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo);
      exp_q.push_back(hi);
      exp_q.push_back(lo);
   endtask

   task automatic check_hilo(input string tag);
      logic [31:0] e_hi, e_lo;
      e_hi = exp_q.pop_front();
      e_lo = exp_q.pop_front();
      check({tag, "_HI"}, bus.HI, e_hi);
      check({tag, "_LO"}, bus.LO, e_lo);
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      bus.Req   = 1'b0;
      bus.md_op = NONE;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      reset     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.md_op = MFHI;
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_hilo_res", bus.HILO_res, 32'd0);
      push_exp(32'd0, 32'd0);
      check_hilo("rst");
      @(negedge clk);
      bus.md_op = NONE;
      reset = 1'b1;

      // MULT -2 * 3
      issue(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult", 1'b1);
      check("mult_dbg_state", 32'(dbg_state), 32'(RUN));
      count_busy(n);
      check("mult_busy_cycles", 32'(n), 32'd5);
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA);
      check_hilo("mult");
      bus.md_op = MFHI;
      #1;
      check("mfhi", bus.HILO_res, 32'hFFFF_FFFF);
      bus.md_op = MFLO;
      #1;
      check("mflo", bus.HILO_res, 32'hFFFF_FFFA);
      bus.md_op = NONE;

      // MULTU max * max
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu", 1'b1);
      count_busy(n);
      check("multu_busy_cycles", 32'(n), 32'd5);
      push_exp(32'hFFFF_FFFE, 32'h0000_0001);
      check_hilo("multu");

      // DIV -7 / 2 and DIVU same operands
      issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div", 1'b1);
      count_busy(n);
      check("div_busy_cycles", 32'(n), 32'd10);
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      check_hilo("div");
      issue(DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, "divu", 1'b1);
      count_busy(n);
      check("divu_busy_cycles", 32'(n), 32'd10);
      push_exp(32'h0000_0001, 32'h7FFF_FFFC);
      check_hilo("divu");

      // MTLO suppressed by Req, then accepted
      issue(MTLO, 32'h1234_5678, 32'd0, 1'b1, "mtlo_req", 1'b0);
      check("mtlo_req_busy", 32'(bus.busy), 32'd0);
      push_exp(32'h0000_0001, 32'h7FFF_FFFC);
      check_hilo("mtlo_req");
      issue(MTLO, 32'h1234_5678, 32'd0, 1'b0, "mtlo", 1'b0);
      check("mtlo_busy", 32'(bus.busy), 32'd0);
      push_exp(32'h0000_0001, 32'h1234_5678);
      check_hilo("mtlo");

      // MULT suppressed by Req
      issue(MULT, 32'd7, 32'd9, 1'b1, "mult_req", 1'b0);
      check("mult_req_busy", 32'(bus.busy), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      push_exp(32'h0000_0001, 32'h1234_5678);
      check_hilo("mult_req");

      // INT_MIN / -1
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf", 1'b1);
      count_busy(n);
      check("div_ovf_busy_cycles", 32'(n), 32'd10);
      push_exp(32'h0000_0000, 32'h8000_0000);
      check_hilo("div_ovf");

      // divide by zero leaves HI/LO alone
      issue(MTHI, 32'hAAAA_0000, 32'd0, 1'b0, "mthi", 1'b0);
      issue(MTLO, 32'h0000_5555, 32'd0, 1'b0, "mtlo2", 1'b0);
      issue(DIV, 32'd100, 32'd0, 1'b0, "div0", 1'b1);
      count_busy(n);
      check("div0_busy_cycles", 32'(n), 32'd10);
      push_exp(32'hAAAA_0000, 32'h0000_5555);
      check_hilo("div0");

      // async reset in cycle 3 of a MULT
      issue(MULT, 32'd3, 32'd5, 1'b0, "mult_rst", 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      push_exp(32'd0, 32'd0);
      check_hilo("arst");
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("arst_after_busy", 32'(bus.busy), 32'd0);
      push_exp(32'd0, 32'd0);
      check_hilo("arst_after");

`ifdef MD_MADD_EN
      issue(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_pre", 1'b0);
      issue(MADDU, 32'd1, 32'd1, 1'b0, "maddu", 1'b1);
      count_busy(n);
      check("maddu_busy_cycles", 32'(n), 32'd5);
      push_exp(32'h0000_0001, 32'h0000_0000);
      check_hilo("maddu");
`else
      issue(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, "madd_pre", 1'b0);
      issue(MADDU, 32'd1, 32'd1, 1'b0, "maddu_off", 1'b0);
      check("maddu_off_busy", 32'(bus.busy), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      push_exp(32'h0000_0000, 32'hFFFF_FFFF);
      check_hilo("maddu_off");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
